conv_mac_pipe: RTL
==================

Name: conv_mac_pipe

Overview:
Parametrised, pipelined signed multiply-accumulate unit for convolution kernels.
- Multiplies din0 by din1 every enabled cycle through a NUM_STAGE-deep registered multiplier (DSP-inferable).
- Accumulates TAPS consecutive valid products and emits one kernel result with a single-cycle out_valid pulse.
- Sits between the line-buffer/weight fetch and the conv output writer; supersedes the fixed 16x8 combinational multiplier.

Parameters:
DIN0_WIDTH, 16, signed activation width
DIN1_WIDTH, 8, signed weight width
NUM_STAGE, 2, multiplier pipeline registers (>=1)
ACC_WIDTH, 32, signed accumulator width (>= DIN0_WIDTH+DIN1_WIDTH)
DOUT_WIDTH, 32, result width (<= ACC_WIDTH)
TAPS, 9, products per kernel result (>=1)

Ports:
ap_clk  in  1  clock, all logic rising-edge
ap_rst_n  in  1  synchronous active-low reset
ce  in  1  clock enable; 0 freezes the entire pipeline
clear  in  1  synchronous flush of in-flight data and accumulator
in_valid  in  1  din0/din1 valid this cycle
din0  in  DIN0_WIDTH  signed activation
din1  in  DIN1_WIDTH  signed weight
out_valid  out  1  one-cycle pulse: dout holds a new kernel result
dout  out  DOUT_WIDTH  signed kernel sum
sat_flag  out  1  result was clipped (only under macro; otherwise constant 0)

Behaviour:
- Reset (ap_rst_n=0 at edge): out_valid=0, dout=0, sat_flag=0, accumulator=0, tap counter=0, all pipeline valid bits=0. Reset overrides clear and ce.
- Multiplier pipeline:
  - Product is full width, DIN0_WIDTH+DIN1_WIDTH, signed.
  - in_valid travels alongside the data through NUM_STAGE registers.
  - Registers advance only when ce=1.
- Accumulate stage (one register, ce-gated), active when the product valid bit is 1:
  - Tap counter == 0: acc = sext(product). A new group needs no dead cycle.
  - Otherwise: acc = acc + sext(product), two's-complement wrap at ACC_WIDTH.
  - Tap counter increments and wraps from TAPS-1 to 0.
  - On the TAPS-th product: acc_done=1 on the next edge.
- Output register (ce-gated):
  - When acc_done: dout = acc[DOUT_WIDTH-1:0], out_valid=1.
  - Otherwise out_valid=0 and dout holds its last value.
- Latency: out_valid rises NUM_STAGE+2 enabled cycles after the cycle carrying the TAPS-th valid input. Throughput is one input per cycle; back-to-back groups produce pulses exactly TAPS cycles apart.
- in_valid=0 cycles are bubbles. They neither count nor accumulate; group membership is by valid count only.
- ce=0: no register changes. out_valid holds its current value but is qualified by ce downstream, so a pulse is seen exactly once per ce-high cycle.
- clear=1 (independent of ce): zeroes pipeline valid bits, tap counter, accumulator and acc_done, and sets out_valid=0 on the next edge. dout is retained. An input presented in the same cycle as clear is discarded.
- TAPS=1: every valid product produces a result.

Optional Feature:
CONV_MAC_SAT_EN
- Defined:
  - The accumulator add saturates at the signed ACC_WIDTH limits and stays saturated for the rest of the group.
  - dout saturates to the signed DOUT_WIDTH range instead of truncating.
  - sat_flag is registered with dout: 1 if any clip occurred in that group, else 0.
  - Adds one comparator level to the accumulate stage; latency unchanged.
- Undefined: wrap/truncate arithmetic as above; sat_flag tied to 0.

Test Plan:
- Defaults. Nine consecutive valid inputs din0=100, din1=-3 -> single out_valid pulse 4 cycles after the 9th input, dout=-2700; no other pulses.
- Two groups back-to-back. 9x(1,1) then 9x(2,5) with no gaps -> pulses 9 cycles apart, dout=9 then 90.
- ce stall and bubbles. Nine inputs (7,7) with ce low for 3 cycles after input 4 and in_valid=0 for 2 cycles after input 6 -> dout=441, pulse delayed by exactly 3+2 cycles versus the unstalled run.
- clear mid-group. Four inputs (50,50), then clear, then 9x(1,1) -> only one pulse, dout=9. A clear pulse asserted with a valid input drops that input.
- Overflow, ACC_WIDTH=24, DOUT_WIDTH=24, 9x(-32768,-128). Without macro: dout=4194304, sat_flag=0. With CONV_MAC_SAT_EN: dout=8388607, sat_flag=1.
- Reset mid-operation. Assert ap_rst_n=0 for 1 cycle after input 5 -> outputs 0 next cycle; a following 9x(3,-2) group gives dout=-54 with no stale contribution.

Source files
------------

// File: rtl/conv_mac_pipe.sv
// rtl/conv_mac_pipe.sv - pipelined signed MAC; TAPS products per result pulse.
// Optional saturating arithmetic with sat_flag when CONV_MAC_SAT_EN is defined.
module conv_mac_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 8,
  parameter int NUM_STAGE  = 2,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 32,
  parameter int TAPS       = 9
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ce,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         out_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         sat_flag
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic signed [PW-1:0]         prod_q [NUM_STAGE];
  logic signed [PW-1:0]         prod_d [NUM_STAGE];
  logic [NUM_STAGE-1:0]         pv_q, pv_d;
  logic [TW-1:0]                tap_q, tap_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         acc_done_q, acc_done_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic signed [ACC_WIDTH-1:0]  prod_ext;

  assign prod_ext = ACC_WIDTH'(prod_q[NUM_STAGE-1]);

`ifdef CONV_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] AMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] DMAX =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] DMIN = ~DMAX;

  logic                 acc_sat_q, acc_sat_d;
  logic                 sat_q, sat_d;
  logic signed [ACC_WIDTH:0] sum_w;

  assign sum_w = {acc_q[ACC_WIDTH-1], acc_q} + {prod_ext[ACC_WIDTH-1], prod_ext};
`endif

  always_comb begin
    prod_d      = prod_q;
    pv_d        = pv_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    acc_done_d  = acc_done_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
`ifdef CONV_MAC_SAT_EN
    acc_sat_d   = acc_sat_q;
    sat_d       = sat_q;
`endif
    if (ce) begin
      prod_d[0] = din0 * din1;
      pv_d[0]   = in_valid;
      for (int s = 1; s < NUM_STAGE; s++) begin
        prod_d[s] = prod_q[s-1];
        pv_d[s]   = pv_q[s-1];
      end
      acc_done_d = 1'b0;
      if (pv_q[NUM_STAGE-1]) begin
        // First tap of a group reloads rather than adds, so groups need no gap.
        if (tap_q == '0) begin
          acc_d = prod_ext;
`ifdef CONV_MAC_SAT_EN
          acc_sat_d = 1'b0;
        end else if (acc_sat_q) begin
          acc_d = acc_q;
        end else if (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]) begin
          acc_d     = sum_w[ACC_WIDTH] ? AMIN : AMAX;
          acc_sat_d = 1'b1;
        end else begin
          acc_d = sum_w[ACC_WIDTH-1:0];
`else
        end else begin
          acc_d = acc_q + prod_ext;
`endif
        end
        if (tap_q == TW'(TAPS-1)) begin
          tap_d      = '0;
          acc_done_d = 1'b1;
        end else begin
          tap_d = tap_q + TW'(1);
        end
      end
      out_valid_d = acc_done_q;
      if (acc_done_q) begin
`ifdef CONV_MAC_SAT_EN
        if (acc_q > DMAX) begin
          dout_d = DMAX[DOUT_WIDTH-1:0];
          sat_d  = 1'b1;
        end else if (acc_q < DMIN) begin
          dout_d = DMIN[DOUT_WIDTH-1:0];
          sat_d  = 1'b1;
        end else begin
          dout_d = acc_q[DOUT_WIDTH-1:0];
          sat_d  = acc_sat_q;
        end
`else
        dout_d = acc_q[DOUT_WIDTH-1:0];
`endif
      end
    end
    // Flush ignores ce; dout is deliberately retained.
    if (clear) begin
      pv_d        = '0;
      tap_d       = '0;
      acc_d       = '0;
      acc_done_d  = 1'b0;
      out_valid_d = 1'b0;
`ifdef CONV_MAC_SAT_EN
      acc_sat_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int s = 0; s < NUM_STAGE; s++) prod_q[s] <= '0;
      pv_q        <= '0;
      tap_q       <= '0;
      acc_q       <= '0;
      acc_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
`ifdef CONV_MAC_SAT_EN
      acc_sat_q   <= 1'b0;
      sat_q       <= 1'b0;
`endif
    end else begin
      prod_q      <= prod_d;
      pv_q        <= pv_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      acc_done_q  <= acc_done_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
`ifdef CONV_MAC_SAT_EN
      acc_sat_q   <= acc_sat_d;
      sat_q       <= sat_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
`ifdef CONV_MAC_SAT_EN
  assign sat_flag  = sat_q;
`else
  assign sat_flag  = 1'b0;
`endif

endmodule
